fb_calc_nbunch: RTL

Parametrised feedback-calculation datapath for multi-bunch trains. It sits between the charge-normalisation LUT and the feedback DAC driver. Each cycle it forms charge × position signal and adds a per-bunch delayed correction (previous turn's output plus banana correction), then emits a saturated output word. It also generates the feedback-enable window relative to each bunch strobe. Unlike the single-bunch generation, it supports N bunches, a configurable sample point and window, and a non-wrapping counter, and it saturates rather than truncates.

---
 rtl/fb_calc_pkg.sv | 30 +++
 rtl/fb_calc_mac.sv | 62 ++++++
 rtl/fb_calc_nbunch.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fb_calc_pkg.sv
// Shared widths and arithmetic helpers for the multi-bunch feedback calculator.
package fb_calc_pkg;

  localparam int unsigned CHARGE_W_DEF = 21;
  localparam int unsigned SIG_W_DEF    = 15;
  localparam int unsigned OUT_W_DEF    = 13;
  localparam int unsigned FRAC_SH_DEF  = 12;
  localparam int unsigned N_BUNCH_DEF  = 2;
  localparam int unsigned CNT_W_DEF    = 8;

  // Clip a sign-extended value into the signed range of out_w bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] val,
                                                    input int unsigned       out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (val > hi)
      return hi;
    else if (val < lo)
      return lo;
    else
      return val;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fb_calc_mac.sv
// Three-stage multiply / correction-add / shift-saturate pipeline.
module fb_calc_mac
  import fb_calc_pkg::*;
#(
  parameter int unsigned CHARGE_W = CHARGE_W_DEF,
  parameter int unsigned SIG_W    = SIG_W_DEF,
  parameter int unsigned OUT_W    = OUT_W_DEF,
  parameter int unsigned FRAC_SH  = FRAC_SH_DEF,
  parameter int unsigned N_BUNCH  = N_BUNCH_DEF,
  parameter int unsigned IDX_W    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [CHARGE_W-1:0] charge_in,
  input  logic signed [SIG_W-1:0]    signal_in,
  input  logic [IDX_W-1:0]           idx_in,
  input  logic [N_BUNCH*OUT_W-1:0]   dly_flat,
  output logic signed [OUT_W-1:0]    pout,
  output logic                       sat
);

  localparam int unsigned PROD_W = CHARGE_W + SIG_W;
  localparam int unsigned SUM_W  = PROD_W + 1;

  logic signed [PROD_W-1:0] prod_s1;
  logic [IDX_W-1:0]         idx_s1;
  logic signed [SUM_W-1:0]  sum_s2;
  logic signed [OUT_W-1:0]  dly_sel;
  logic signed [SUM_W-1:0]  corr_ext;
  logic signed [63:0]       shifted;
  logic signed [OUT_W-1:0]  pout_next;
  logic                     clip;

  always_comb begin
    dly_sel = '0;
    for (int unsigned b = 0; b < N_BUNCH; b++) begin
      if (idx_s1 == IDX_W'(b))
        dly_sel = dly_flat[b*OUT_W +: OUT_W];
    end
    corr_ext  = {{(SUM_W-OUT_W){dly_sel[OUT_W-1]}}, dly_sel} <<< FRAC_SH;
    shifted   = $signed({{(64-SUM_W){sum_s2[SUM_W-1]}}, sum_s2}) >>> FRAC_SH;
    pout_next = OUT_W'(sat_signed(shifted, OUT_W));
    clip      = ({{(64-OUT_W){pout_next[OUT_W-1]}}, pout_next} != shifted);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_s1 <= '0;
      idx_s1  <= '0;
      sum_s2  <= '0;
      pout    <= '0;
      sat     <= 1'b0;
    end else begin
      prod_s1 <= charge_in * signal_in;
      idx_s1  <= idx_in;
      sum_s2  <= $signed({prod_s1[PROD_W-1], prod_s1}) + corr_ext;
      pout    <= pout_next;
      sat     <= clip;
    end
  end

endmodule

// File: rtl/fb_calc_nbunch.sv
// Multi-bunch feedback calculator: sample counter, bunch index, per-bunch
// correction bank and feedback window around the fb_calc_mac pipeline.
module fb_calc_nbunch
  import fb_calc_pkg::*;
#(
  parameter int unsigned CHARGE_W   = CHARGE_W_DEF,
  parameter int unsigned SIG_W      = SIG_W_DEF,
  parameter int unsigned OUT_W      = OUT_W_DEF,
  parameter int unsigned FRAC_SH    = FRAC_SH_DEF,
  parameter int unsigned N_BUNCH    = N_BUNCH_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned SAMPLE_IDX = 5,
  parameter int unsigned FB_START   = 3,
  parameter int unsigned FB_LEN     = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               store_strb,
  input  logic                               bunch_strb,
  input  logic signed [CHARGE_W-1:0]         charge_in,
  input  logic signed [SIG_W-1:0]            signal_in,
  input  logic                               delay_en,
  input  logic [N_BUNCH*OUT_W-1:0]           banana_corr,
  output logic signed [OUT_W-1:0]            pout,
  output logic                               fb_cond,
  output logic [idx_width(N_BUNCH)-1:0]      bunch_idx,
  output logic                               sat,
  output logic                               idx_ovf
);

  localparam int unsigned IDX_W = idx_width(N_BUNCH);

  logic [CNT_W-1:0]        j;
  logic                    first;
  logic signed [OUT_W-1:0] acc [N_BUNCH];
  logic signed [OUT_W-1:0] dly [N_BUNCH];
  logic [N_BUNCH*OUT_W-1:0] dly_flat;
  logic                    capture;
  logic                    in_window;
  logic signed [OUT_W-1:0] ban_sel;
  logic signed [63:0]      pout_ext;
  logic signed [63:0]      ban_ext;
  logic signed [OUT_W-1:0] acc_next;

  always_comb begin
    capture   = store_strb && delay_en && (j == CNT_W'(SAMPLE_IDX));
    in_window = (j >= CNT_W'(FB_START)) && (j <= CNT_W'(FB_START + FB_LEN - 1));
    ban_sel   = '0;
    dly_flat  = '0;
    for (int unsigned b = 0; b < N_BUNCH; b++) begin
      if (bunch_idx == IDX_W'(b))
        ban_sel = banana_corr[b*OUT_W +: OUT_W];
      dly_flat[b*OUT_W +: OUT_W] = dly[b];
    end
    pout_ext = {{(64-OUT_W){pout[OUT_W-1]}}, pout};
    ban_ext  = {{(64-OUT_W){ban_sel[OUT_W-1]}}, ban_sel};
    acc_next = OUT_W'(sat_signed(pout_ext + (ban_ext >>> 2), OUT_W));
  end

  // store_strb low outranks bunch_strb; the counter parks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || !store_strb)
      j <= '1;
    else if (bunch_strb)
      j <= '0;
    else if (j != '1)
      j <= j + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || !store_strb) begin
      bunch_idx <= '0;
      first     <= 1'b1;
      idx_ovf   <= 1'b0;
    end else if (bunch_strb) begin
      if (first)
        first <= 1'b0;
      else if (bunch_idx == IDX_W'(N_BUNCH - 1))
        idx_ovf <= 1'b1;
      else
        bunch_idx <= bunch_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !store_strb) begin
      for (int unsigned b = 0; b < N_BUNCH; b++)
        acc[b] <= '0;
    end else if (capture) begin
      for (int unsigned b = 0; b < N_BUNCH; b++) begin
        if (bunch_idx == IDX_W'(b))
          acc[b] <= acc_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < N_BUNCH; b++)
      dly[b] <= rst ? '0 : acc[b];
  end

  always_ff @(posedge clk) begin
    if (rst)
      fb_cond <= 1'b0;
    else
      fb_cond <= store_strb && in_window;
  end

  fb_calc_mac #(
    .CHARGE_W (CHARGE_W),
    .SIG_W    (SIG_W),
    .OUT_W    (OUT_W),
    .FRAC_SH  (FRAC_SH),
    .N_BUNCH  (N_BUNCH),
    .IDX_W    (IDX_W)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .charge_in (charge_in),
    .signal_in (signal_in),
    .idx_in    (bunch_idx),
    .dly_flat  (dly_flat),
    .pout      (pout),
    .sat       (sat)
  );

endmodule
